cc_unit_param: RTL

- Parametrised condition-code unit for the pipelined Y86 core, sitting in the Execute stage.
- Computes ZF/SF/OF/CF from the ALU operation and result, and holds them in a 4-bit CC register.
- Evaluates the jXX/cmovXX condition from the registered flags, including the extended unsigned conditions.
- Pipelines the result into a Memory-stage register with stall/bubble control, and keeps a saturating taken-condition counter for performance monitoring.

---
 rtl/cc_unit_param.sv | 114 +++++++++++
 1 files changed

// File: rtl/cc_unit_param.sv
// Execute-stage condition-code unit: flag generation, CC register, jXX/cmovXX
// condition evaluation, M-stage condition register and a saturating taken counter.
module cc_unit_param #(
  parameter int W        = 64,
  parameter bit EXT_COND = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_cc,
  input  logic             cc_hold,
  input  logic [3:0]       alu_fun,
  input  logic [W-1:0]     alu_a,
  input  logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_e,
  input  logic [3:0]       ifun,
  input  logic             cnd_en,
  input  logic             stall,
  input  logic             bubble,
  input  logic             cnt_clr,
  output logic [3:0]       cc_out,
  output logic             e_cnd,
  output logic             m_cnd,
  output logic             m_illegal,
  output logic [CNT_W-1:0] taken_cnt
);

  logic       zf_n, sf_n, of_n, cf_n;
  logic       add_carry, sub_borrow;
  logic       illegal;
  logic       zf, sf, of, cf;

  // b + a carries out exactly when b exceeds the headroom left above a (~a).
  assign add_carry  = (alu_b > ~alu_a);
  assign sub_borrow = (alu_b < alu_a);

  always_comb begin
    zf_n = (alu_e == '0);
    sf_n = alu_e[W-1];
    of_n = 1'b0;
    cf_n = 1'b0;
    case (alu_fun)
      4'd0: begin
        of_n = (alu_a[W-1] == alu_b[W-1]) & (alu_e[W-1] != alu_b[W-1]);
        cf_n = add_carry;
      end
      4'd1: begin
        of_n = (alu_a[W-1] != alu_b[W-1]) & (alu_e[W-1] != alu_b[W-1]);
        cf_n = sub_borrow;
      end
      default: begin
        of_n = 1'b0;
        cf_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      cc_out <= 4'b1000;
    else if (set_cc && !cc_hold)
      cc_out <= {zf_n, sf_n, of_n, cf_n};
  end

  // Conditions look only at the registered flags, never the ones being written.
  assign {zf, sf, of, cf} = cc_out;

  always_comb begin
    e_cnd   = 1'b0;
    illegal = 1'b0;
    case (ifun)
      4'h0: e_cnd = 1'b1;
      4'h1: e_cnd = (sf ^ of) | zf;
      4'h2: e_cnd = sf ^ of;
      4'h3: e_cnd = zf;
      4'h4: e_cnd = ~zf;
      4'h5: e_cnd = ~(sf ^ of);
      4'h6: e_cnd = ~(sf ^ of) & ~zf;
      4'h7: e_cnd = cf;
      4'h8: e_cnd = cf | zf;
      4'h9: e_cnd = ~cf & ~zf;
      4'hA: e_cnd = ~cf;
      default: illegal = 1'b1;
    endcase
    if (!EXT_COND && (ifun >= 4'h7) && (ifun <= 4'hA)) begin
      e_cnd   = 1'b0;
      illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnd     <= 1'b0;
      m_illegal <= 1'b0;
    end else if (stall) begin
      m_cnd     <= m_cnd;
      m_illegal <= m_illegal;
    end else if (bubble) begin
      m_cnd     <= 1'b0;
      m_illegal <= 1'b0;
    end else begin
      m_cnd     <= e_cnd;
      m_illegal <= illegal & cnd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      taken_cnt <= '0;
    else if (cnd_en && e_cnd && !stall && (taken_cnt != '1))
      taken_cnt <= taken_cnt + CNT_W'(1);
  end

endmodule
